// File: rtl/i2c_slave_rx.sv
// I2C target endpoint: oversampled SCL/SDA, fixed 7-bit address, ACKed write bytes.
// Define I2C_SLAVE_READ_EN to build the master-read path (RDATA/RDATA_ACK, tx_req).
module i2c_slave_rx #(
    parameter logic [6:0] SLV_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCL,
    inout  wire        SDA,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic [7:0] state_led
);

    localparam logic [7:0] IDLE      = 8'h01;
    localparam logic [7:0] ADDR      = 8'h02;
    localparam logic [7:0] ADDR_ACK  = 8'h04;
    localparam logic [7:0] WDATA     = 8'h08;
    localparam logic [7:0] WDATA_ACK = 8'h10;
    localparam logic [7:0] WAIT_STOP = 8'h80;
`ifdef I2C_SLAVE_READ_EN
    localparam logic [7:0] RDATA     = 8'h20;
    localparam logic [7:0] RDATA_ACK = 8'h40;
`endif

    logic [SYNC_STAGES-1:0] scl_pipe;
    logic [SYNC_STAGES-1:0] sda_pipe;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start;
    logic                   stop;

    logic [7:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic       sda_drive;
    logic       byte_end;
    logic       addr_hit;

`ifdef I2C_SLAVE_READ_EN
    logic [7:0] tx_shift;
    logic       ack_seen;
    logic       rw;
    logic       tx_req_r;
`else
    logic       tx_unused;
`endif

    // Pipes reset to the idle-high bus level so reset release raises no edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], SCL};
            sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], SDA};
            scl_prev <= scl_pipe[SYNC_STAGES-1];
            sda_prev <= sda_pipe[SYNC_STAGES-1];
        end
    end

    assign scl_s    = scl_pipe[SYNC_STAGES-1];
    assign sda_s    = sda_pipe[SYNC_STAGES-1];
    assign scl_rise = scl_s && !scl_prev;
    assign scl_fall = !scl_s && scl_prev;
    assign start    = scl_s && scl_prev && sda_prev && !sda_s;
    assign stop     = scl_s && scl_prev && !sda_prev && sda_s;
    assign byte_end = (bit_cnt == 4'd7);

    // Without the read path a read request to our address is simply not ACKed.
`ifdef I2C_SLAVE_READ_EN
    assign addr_hit = (shift[6:0] == SLV_ADDR);
    assign tx_req   = tx_req_r;
`else
    assign addr_hit  = (shift[6:0] == SLV_ADDR) && !sda_s;
    assign tx_req    = 1'b0;
    assign tx_unused = ^tx_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            sda_drive <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
            tx_shift  <= '0;
            ack_seen  <= 1'b0;
            rw        <= 1'b0;
            tx_req_r  <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
            tx_req_r <= 1'b0;
`endif
            if (stop) begin
                state     <= IDLE;
                bit_cnt   <= '0;
                sda_drive <= 1'b0;
                busy      <= 1'b0;
            end else if (start) begin
                state     <= ADDR;
                bit_cnt   <= '0;
                sda_drive <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift <= {shift[6:0], sda_s};
                            if (byte_end) begin
                                bit_cnt <= '0;
`ifdef I2C_SLAVE_READ_EN
                                rw      <= sda_s;
`endif
                                if (addr_hit) begin
                                    state <= ADDR_ACK;
                                    busy  <= 1'b1;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ADDR_ACK, WDATA_ACK: begin
`ifdef I2C_SLAVE_READ_EN
                        if (scl_rise && sda_drive && rw)
                            tx_req_r <= 1'b1;
`endif
                        // First fall drives the ACK, the next one ends it.
                        if (scl_fall) begin
                            if (!sda_drive) begin
                                sda_drive <= 1'b1;
                            end
`ifdef I2C_SLAVE_READ_EN
                            else if (rw) begin
                                tx_shift  <= tx_data;
                                sda_drive <= !tx_data[7];
                                bit_cnt   <= '0;
                                state     <= RDATA;
                            end
`endif
                            else begin
                                sda_drive <= 1'b0;
                                state     <= WDATA;
                            end
                        end
                    end
                    WDATA: begin
                        if (scl_rise) begin
                            shift <= {shift[6:0], sda_s};
                            if (byte_end) begin
                                rx_data  <= {shift[6:0], sda_s};
                                rx_valid <= 1'b1;
                                bit_cnt  <= '0;
                                state    <= WDATA_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
`ifdef I2C_SLAVE_READ_EN
                    RDATA: begin
                        if (scl_fall) begin
                            if (byte_end) begin
                                sda_drive <= 1'b0;
                                bit_cnt   <= '0;
                                ack_seen  <= 1'b0;
                                state     <= RDATA_ACK;
                            end else begin
                                tx_shift  <= {tx_shift[6:0], 1'b0};
                                sda_drive <= !tx_shift[6];
                                bit_cnt   <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_s) begin
                                state <= WAIT_STOP;
                            end else begin
                                ack_seen <= 1'b1;
                                tx_req_r <= 1'b1;
                            end
                        end else if (scl_fall && ack_seen) begin
                            tx_shift  <= tx_data;
                            sda_drive <= !tx_data[7];
                            bit_cnt   <= '0;
                            state     <= RDATA;
                        end
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

    assign SDA       = (sda_drive && !reset) ? 1'b0 : 1'bz;
    assign state_led = state;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-banged bus master, randomized traffic, transaction model.
// Builds the read or read-disabled scenario depending on I2C_SLAVE_READ_EN.
`timescale 1ns/100ps
module tb_i2c_slave_rx;

    localparam int Q = 40;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       scl     = 1'b1;
    logic       m_low   = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda;
    logic [7:0] rx_data;
    logic [7:0] state_led;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_slave_rx dut (
        .clk(clk),
        .reset(reset),
        .SCL(scl),
        .SDA(sda),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_data(tx_data),
        .tx_req(tx_req),
        .busy(busy),
        .state_led(state_led)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] rx_got[$];
    logic [7:0] tx_q[$];
    int tx_idx = 0;
    int tx_req_cnt = 0;
    int drive_cnt = 0;
    int busy_cnt = 0;
    int rx_long = 0;
    logic rx_valid_d = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) rx_got.push_back(rx_data);
        if (rx_valid && rx_valid_d) rx_long++;
        rx_valid_d = rx_valid;
        if (tx_req) begin
            tx_req_cnt++;
            if (tx_idx < tx_q.size()) tx_data = tx_q[tx_idx];
            tx_idx++;
        end
        if (!m_low && sda == 1'b0) drive_cnt++;
        if (busy) busy_cnt++;
    end

    // Reference: which address bytes this target answers.
    function automatic logic addr_hit(input logic [7:0] a);
`ifdef I2C_SLAVE_READ_EN
        return a[7:1] == 7'h42;
`else
        return (a[7:1] == 7'h42) && !a[0];
`endif
    endfunction

    task automatic bus_start();
        m_low = 1'b0; #Q;
        scl = 1'b1; #Q;
        m_low = 1'b1; #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        m_low = 1'b1; #Q;
        scl = 1'b1; #Q;
        m_low = 1'b0; #(2*Q);
    endtask

    task automatic bus_bit(input logic b, output logic s);
        m_low = !b; #Q;
        scl = 1'b1; #Q;
        s = sda; #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = !s;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            b[i] = s;
        end
        bus_bit(!ack, s);
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #20;
        checks++; if (rx_data !== 8'h00) begin errors++;
            $display("FAIL reset_rx_data got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++;
            $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        checks++; if (tx_req !== 1'b0) begin errors++;
            $display("FAIL reset_tx_req got %b want 0", tx_req); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (state_led !== 8'h01) begin errors++;
            $display("FAIL reset_state_led got %h want 01", state_led); end
        checks++; if (sda !== 1'b1) begin errors++;
            $display("FAIL reset_sda got %b want released", sda); end
        #3 reset = 1'b0;
        #(2*Q);
    endtask

    task automatic test_write_one();
        logic ack;
        int base;
        base = rx_got.size();
        bus_start();
        send_byte(8'h84, ack);
        checks++; if (ack !== 1'b1) begin errors++;
            $display("FAIL wr1_addr_ack got %b want 1", ack); end
        checks++; if (busy !== 1'b1) begin errors++;
            $display("FAIL wr1_busy got %b want 1", busy); end
        send_byte(8'hA5, ack);
        checks++; if (ack !== 1'b1) begin errors++;
            $display("FAIL wr1_data_ack got %b want 1", ack); end
        bus_stop();
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL wr1_busy_stop got %b want 0", busy); end
        checks++; if (state_led !== 8'h01) begin errors++;
            $display("FAIL wr1_idle got %h want 01", state_led); end
        checks++; if (rx_got.size() - base !== 1) begin errors++;
            $display("FAIL wr1_rx_count got %0d want 1", rx_got.size() - base); end
        else begin
            checks++; if (rx_got[base] !== 8'hA5) begin errors++;
                $display("FAIL wr1_rx_data got %h want a5", rx_got[base]); end
        end
    endtask

    task automatic test_addr_miss();
        logic ack;
        int base, d0, b0;
        base = rx_got.size();
        d0 = drive_cnt;
        b0 = busy_cnt;
        bus_start();
        send_byte(8'h86, ack);
        checks++; if (ack !== 1'b0) begin errors++;
            $display("FAIL miss_addr_ack got %b want 0", ack); end
        send_byte(8'h11, ack);
        checks++; if (ack !== 1'b0) begin errors++;
            $display("FAIL miss_data_ack got %b want 0", ack); end
        bus_stop();
        checks++; if (drive_cnt != d0) begin errors++;
            $display("FAIL miss_sda_driven got %0d want 0", drive_cnt - d0); end
        checks++; if (busy_cnt != b0) begin errors++;
            $display("FAIL miss_busy got %0d cycles want 0", busy_cnt - b0); end
        checks++; if (rx_got.size() != base) begin errors++;
            $display("FAIL miss_rx got %0d want 0", rx_got.size() - base); end
    endtask

    task automatic test_burst();
        logic ack, hit, open;
        logic [7:0] a, d;
        logic [7:0] exp[$];
        int bad, base, n;
        base = rx_got.size();
        bad = 0;
        bus_start();
        send_byte(8'h84, ack); if (!ack) bad++;
        for (int i = 1; i <= 3; i++) begin
            send_byte(8'(i), ack); if (!ack) bad++;
            exp.push_back(8'(i));
        end
        bus_start();
        send_byte(8'h84, ack); if (!ack) bad++;
        send_byte(8'h04, ack); if (!ack) bad++;
        exp.push_back(8'h04);
        bus_stop();
        checks++; if (bad != 0) begin errors++;
            $display("FAIL burst_acks got %0d bad want 0", bad); end
        open = 1'b0;
        for (int t = 0; t < 8; t++) begin
            a = ($urandom_range(0, 1) == 1) ? 8'h84 : {7'($urandom), 1'b0};
            hit = addr_hit(a);
            n = $urandom_range(1, 4);
            bad = 0;
            bus_start();
            send_byte(a, ack); if (ack !== hit) bad++;
            for (int j = 0; j < n; j++) begin
                d = 8'($urandom);
                send_byte(d, ack); if (ack !== hit) bad++;
                if (hit) exp.push_back(d);
            end
            open = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                bus_stop();
                open = 1'b0;
            end
            checks++; if (bad != 0) begin errors++;
                $display("FAIL rand_wr_acks addr %h got %0d bad want 0", a, bad); end
        end
        if (open) bus_stop();
        checks++; if (rx_got.size() - base != exp.size()) begin errors++;
            $display("FAIL burst_rx_count got %0d want %0d", rx_got.size() - base, exp.size()); end
        else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++; if (rx_got[base+i] !== exp[i]) begin errors++;
                    $display("FAIL burst_rx_byte%0d got %h want %h", i, rx_got[base+i], exp[i]); end
            end
        end
        checks++; if (rx_long != 0) begin errors++;
            $display("FAIL rx_valid_width got %0d long pulses want 0", rx_long); end
    endtask

`ifdef I2C_SLAVE_READ_EN
    task automatic test_read();
        logic ack;
        logic [7:0] b1, b2, b;
        logic [7:0] exp[$];
        int r0, n;
        r0 = tx_req_cnt;
        tx_q.push_back(8'h3C);
        tx_q.push_back(8'hC3);
        bus_start();
        send_byte(8'h85, ack);
        checks++; if (ack !== 1'b1) begin errors++;
            $display("FAIL rd_addr_ack got %b want 1", ack); end
        recv_byte(1'b1, b1);
        recv_byte(1'b0, b2);
        checks++; if (b1 !== 8'h3C) begin errors++;
            $display("FAIL rd_byte1 got %h want 3c", b1); end
        checks++; if (b2 !== 8'hC3) begin errors++;
            $display("FAIL rd_byte2 got %h want c3", b2); end
        checks++; if (sda !== 1'b1) begin errors++;
            $display("FAIL rd_nack_release got %b want released", sda); end
        bus_stop();
        checks++; if (tx_req_cnt - r0 != 2) begin errors++;
            $display("FAIL rd_tx_req got %0d want 2", tx_req_cnt - r0); end
        checks++; if (state_led !== 8'h01) begin errors++;
            $display("FAIL rd_idle got %h want 01", state_led); end
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            exp.push_back(8'($urandom));
            tx_q.push_back(exp[i]);
        end
        bus_start();
        send_byte(8'h85, ack);
        for (int i = 0; i < n; i++) begin
            recv_byte(i != n - 1, b);
            checks++; if (b !== exp[i]) begin errors++;
                $display("FAIL rand_rd_byte%0d got %h want %h", i, b, exp[i]); end
        end
        bus_stop();
    endtask
`else
    task automatic test_read_disabled();
        logic ack;
        int r0;
        r0 = tx_req_cnt;
        bus_start();
        send_byte(8'h85, ack);
        checks++; if (ack !== 1'b0) begin errors++;
            $display("FAIL rdis_ack got %b want 0", ack); end
        checks++; if (state_led !== 8'h80) begin errors++;
            $display("FAIL rdis_wait_stop got %h want 80", state_led); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL rdis_busy got %b want 0", busy); end
        bus_stop();
        checks++; if (state_led !== 8'h01) begin errors++;
            $display("FAIL rdis_idle got %h want 01", state_led); end
        checks++; if (tx_req_cnt != r0) begin errors++;
            $display("FAIL rdis_tx_req got %0d want 0", tx_req_cnt - r0); end
    endtask
`endif

    task automatic test_reset_mid();
        logic ack, s;
        logic [7:0] d;
        int base;
        d = 8'($urandom);
        bus_start();
        send_byte(8'h84, ack);
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        m_low = 1'b0;
        #20;
        checks++; if (sda !== 1'b0) begin errors++;
            $display("FAIL mid_ack_driven got %b want 0", sda); end
        checks++; if (state_led !== 8'h10) begin errors++;
            $display("FAIL mid_state got %h want 10", state_led); end
        @(negedge clk);
        #1 reset = 1'b1;
        #0.1;
        checks++; if (sda !== 1'b1) begin errors++;
            $display("FAIL mid_sda_release got %b want released", sda); end
        checks++; if (busy !== 1'b0 || rx_valid !== 1'b0 || tx_req !== 1'b0) begin errors++;
            $display("FAIL mid_flags got %b%b%b want 000", busy, rx_valid, tx_req); end
        checks++; if (state_led !== 8'h01 || rx_data !== 8'h00) begin errors++;
            $display("FAIL mid_regs got %h/%h want 01/00", state_led, rx_data); end
        #20 reset = 1'b0;
        #Q scl = 1'b1;
        #(2*Q);
        base = rx_got.size();
        bus_start();
        send_byte(8'h84, ack);
        send_byte(8'h5A, ack);
        bus_stop();
        checks++; if (rx_got.size() - base != 1 || (rx_got.size() > base && rx_got[base] !== 8'h5A))
        begin errors++;
            $display("FAIL mid_recover got %0d bytes want one 5a", rx_got.size() - base); end
    endtask

    initial begin
        test_reset();
        test_write_one();
        test_addr_miss();
        test_burst();
`ifdef I2C_SLAVE_READ_EN
        test_read();
`else
        test_read_disabled();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
